// File: rtl/gb_cpu_common_pkg.sv
// Shared CPU core types: 8-bit register codes, register bank layout,
// context-switch opcodes and register pairing helpers.
package gb_cpu_common_pkg;

  typedef enum logic [3:0] {
    REG_B     = 4'd0,
    REG_C     = 4'd1,
    REG_D     = 4'd2,
    REG_E     = 4'd3,
    REG_H     = 4'd4,
    REG_L     = 4'd5,
    REG_F     = 4'd6,
    REG_A     = 4'd7,
    REG_SP_H  = 4'd8,
    REG_SP_L  = 4'd9,
    REG_PC_H  = 4'd10,
    REG_PC_L  = 4'd11,
    REG_TMP_H = 4'd12,
    REG_TMP_L = 4'd13,
    REG_IR    = 4'd14,
    REG_NONE  = 4'd15
  } regfile_r8_t;

  localparam int NUM_R8    = 15;
  localparam int NUM_PAIRS = 6;

  typedef logic [NUM_R8-1:0][7:0] regfile_t;

  typedef enum logic [1:0] {
    CTX_SAVE    = 2'b00,
    CTX_RESTORE = 2'b01,
    CTX_SWAP    = 2'b10,
    CTX_RSVD    = 2'b11
  } ctx_op_t;

  // Context copy order: AF, BC, DE, HL, SP, PC (high-register codes)
  localparam regfile_r8_t REG_PAIR_ORDER [NUM_PAIRS] = '{
    REG_A, REG_B, REG_D, REG_H, REG_SP_H, REG_PC_H
  };

  // DMG post-boot state; index order IR down to B
  localparam regfile_t REGFILE_RESET_VALUE = {
    8'h00, 8'h00, 8'h00, 8'h00, 8'h01,
    8'hFE, 8'hFF, 8'h01, 8'hB0, 8'h4D,
    8'h01, 8'hD8, 8'h00, 8'h13, 8'h00
  };

  function automatic logic isPairHigh(input regfile_r8_t r);
    case (r)
      REG_A, REG_B, REG_D, REG_H,
      REG_SP_H, REG_PC_H, REG_TMP_H: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

  function automatic regfile_r8_t getRegisterLow(input regfile_r8_t r);
    case (r)
      REG_A:     return REG_F;
      REG_B:     return REG_C;
      REG_D:     return REG_E;
      REG_H:     return REG_L;
      REG_SP_H:  return REG_SP_L;
      REG_PC_H:  return REG_PC_L;
      REG_TMP_H: return REG_TMP_L;
      default:   return r;
    endcase
  endfunction

  function automatic regfile_r8_t getRegisterHigh(input regfile_r8_t r);
    case (r)
      REG_F:     return REG_A;
      REG_C:     return REG_B;
      REG_E:     return REG_D;
      REG_L:     return REG_H;
      REG_SP_L:  return REG_SP_H;
      REG_PC_L:  return REG_PC_H;
      REG_TMP_L: return REG_TMP_H;
      default:   return r;
    endcase
  endfunction

endpackage

// File: rtl/gb_cpu_regfile_ctx_seq.sv
// Context save/restore/swap sequencer: walks the six register pairs
// one per cycle and signals completion with a one-cycle done pulse.
module gb_cpu_regfile_ctx_seq
  import gb_cpu_common_pkg::*;
#(
  parameter int NUM_CTX = 2,
  parameter int SLOT_W  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ctx_valid,
  input  logic [1:0]        ctx_op,
  input  logic [SLOT_W-1:0] ctx_slot,
  output logic              ctx_ready,
  output logic              ctx_done,
  output logic              ctx_err,
  output logic [2:0]        copy_idx,
  output logic              copy_save,
  output logic              copy_restore,
  output logic [SLOT_W-1:0] copy_slot
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COPY,
    S_DONE
  } seq_state_t;

  seq_state_t  state;
  logic [2:0]  cnt;
  logic        bad_req;

  assign bad_req = (ctx_op == CTX_RSVD) ||
                   (32'(ctx_slot) >= NUM_CTX);

  assign copy_idx = cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      cnt          <= 3'd0;
      copy_slot    <= '0;
      ctx_ready    <= 1'b1;
      ctx_done     <= 1'b0;
      ctx_err      <= 1'b0;
      copy_save    <= 1'b0;
      copy_restore <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          ctx_done <= 1'b0;
          ctx_err  <= 1'b0;
          cnt      <= 3'd0;
          if (ctx_valid) begin
            copy_slot <= ctx_slot;
            ctx_ready <= 1'b0;
            if (bad_req) begin
              state    <= S_DONE;
              ctx_done <= 1'b1;
              ctx_err  <= 1'b1;
            end else begin
              state        <= S_COPY;
              copy_save    <= (ctx_op == CTX_SAVE) ||
                              (ctx_op == CTX_SWAP);
              copy_restore <= (ctx_op == CTX_RESTORE) ||
                              (ctx_op == CTX_SWAP);
            end
          end
        end
        S_COPY: begin
          cnt <= cnt + 3'd1;
          if (cnt == 3'(NUM_PAIRS - 1)) begin
            state        <= S_DONE;
            cnt          <= 3'd0;
            ctx_done     <= 1'b1;
            copy_save    <= 1'b0;
            copy_restore <= 1'b0;
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          ctx_done  <= 1'b0;
          ctx_err   <= 1'b0;
          ctx_ready <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          ctx_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/gb_cpu_regfile_mp.sv
// Multi-port CPU register file with per-byte write priority, optional
// read bypass and shadow context banks for fast context switching.
module gb_cpu_regfile_mp
  import gb_cpu_common_pkg::*;
#(
  parameter int NUM_WR  = 3,
  parameter int NUM_RD  = 2,
  parameter int NUM_CTX = 2,
  parameter int BYPASS  = 1,
  localparam int SLOT_W = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_WR-1:0]      wr_en,
  input  logic [NUM_WR-1:0]      wr_pair,
  input  logic [NUM_WR*4-1:0]    wr_sel,
  input  logic [NUM_WR*16-1:0]   wr_data,
  output logic                   wr_ready,
  input  logic [NUM_RD-1:0]      rd_pair,
  input  logic [NUM_RD*4-1:0]    rd_sel,
  output logic [NUM_RD*16-1:0]   rd_data,
  input  logic                   ctx_valid,
  input  logic [1:0]             ctx_op,
  input  logic [SLOT_W-1:0]      ctx_slot,
  output logic                   ctx_ready,
  output logic                   ctx_done,
  output logic                   ctx_err,
  output regfile_t               registers
);

  regfile_t          active;
  regfile_t          merged;
  regfile_t          view;
  regfile_t          shadow [NUM_CTX];
  logic [2:0]        copy_idx;
  logic              copy_save;
  logic              copy_restore;
  logic [SLOT_W-1:0] copy_slot;
  regfile_r8_t       cp_hi;
  regfile_r8_t       cp_lo;

  gb_cpu_regfile_ctx_seq #(
    .NUM_CTX (NUM_CTX),
    .SLOT_W  (SLOT_W)
  ) u_ctx_seq (
    .clk          (clk),
    .reset        (reset),
    .ctx_valid    (ctx_valid),
    .ctx_op       (ctx_op),
    .ctx_slot     (ctx_slot),
    .ctx_ready    (ctx_ready),
    .ctx_done     (ctx_done),
    .ctx_err      (ctx_err),
    .copy_idx     (copy_idx),
    .copy_save    (copy_save),
    .copy_restore (copy_restore),
    .copy_slot    (copy_slot)
  );

  assign wr_ready  = ctx_ready;
  assign registers = active;

  // Walk ports from lowest to highest priority so the lowest index lands last
  always_comb begin
    merged = active;
    for (int p = NUM_WR - 1; p >= 0; p--) begin
      if (wr_en[p] && wr_ready) begin
        if (wr_pair[p]) begin
          if (isPairHigh(regfile_r8_t'(wr_sel[p*4 +: 4]))) begin
            merged[wr_sel[p*4 +: 4]] = wr_data[p*16+8 +: 8];
            merged[getRegisterLow(regfile_r8_t'(wr_sel[p*4 +: 4]))] =
              wr_data[p*16 +: 8];
          end
        end else if (regfile_r8_t'(wr_sel[p*4 +: 4]) != REG_NONE) begin
          merged[wr_sel[p*4 +: 4]] = wr_data[p*16 +: 8];
        end
      end
    end
    merged[REG_F][3:0] = 4'h0;
  end

  assign view = (BYPASS != 0) ? merged : active;

  always_comb begin
    rd_data = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      if (rd_pair[r]) begin
        if (isPairHigh(regfile_r8_t'(rd_sel[r*4 +: 4]))) begin
          rd_data[r*16 +: 16] = {
            view[rd_sel[r*4 +: 4]],
            view[getRegisterLow(regfile_r8_t'(rd_sel[r*4 +: 4]))]
          };
        end
      end else if (regfile_r8_t'(rd_sel[r*4 +: 4]) != REG_NONE) begin
        rd_data[r*16 +: 16] = {8'h00, view[rd_sel[r*4 +: 4]]};
      end
    end
  end

  always_comb begin
    cp_hi = REG_A;
    if (copy_idx < 3'(NUM_PAIRS)) begin
      cp_hi = REG_PAIR_ORDER[copy_idx];
    end
    cp_lo = getRegisterLow(cp_hi);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active <= REGFILE_RESET_VALUE;
      for (int i = 0; i < NUM_CTX; i++) begin
        shadow[i] <= '0;
      end
    end else begin
      active <= merged;
      if (copy_restore) begin
        active[cp_hi] <= shadow[copy_slot][cp_hi];
        active[cp_lo] <= (cp_lo == REG_F) ?
          {shadow[copy_slot][cp_lo][7:4], 4'h0} :
          shadow[copy_slot][cp_lo];
      end
      if (copy_save) begin
        shadow[copy_slot][cp_hi] <= active[cp_hi];
        shadow[copy_slot][cp_lo] <= active[cp_lo];
      end
    end
  end

  a_no_write_busy: assert property (
    @(posedge clk) disable iff (!reset)
    !((|wr_en) && !wr_ready)
  );

endmodule

// File: tb/tb_gb_cpu_regfile_mp.sv
// Randomised bench for gb_cpu_regfile_mp against a byte-array model,
// one bypassing and one non-bypassing instance on shared stimulus.
module tb_gb_cpu_regfile_mp;
  import gb_cpu_common_pkg::*;

  localparam int NW = 3;
  localparam int NR = 2;
  localparam int NC = 3;

  logic             clk;
  logic             reset;
  logic [NW-1:0]    wr_en;
  logic [NW-1:0]    wr_pair;
  logic [NW*4-1:0]  wr_sel;
  logic [NW*16-1:0] wr_data;
  logic [NR-1:0]    rd_pair;
  logic [NR*4-1:0]  rd_sel;
  logic             ctx_valid;
  logic [1:0]       ctx_op;
  logic [1:0]       ctx_slot;

  logic             wr_ready_b, wr_ready_n;
  logic [NR*16-1:0] rd_data_b, rd_data_n;
  logic             ctx_ready_b, ctx_ready_n;
  logic             ctx_done_b, ctx_done_n;
  logic             ctx_err_b, ctx_err_n;
  regfile_t         registers_b, registers_n;

  gb_cpu_regfile_mp #(
    .NUM_WR(NW), .NUM_RD(NR), .NUM_CTX(NC), .BYPASS(1)
  ) dut_b (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_pair(wr_pair), .wr_sel(wr_sel),
    .wr_data(wr_data), .wr_ready(wr_ready_b),
    .rd_pair(rd_pair), .rd_sel(rd_sel), .rd_data(rd_data_b),
    .ctx_valid(ctx_valid), .ctx_op(ctx_op), .ctx_slot(ctx_slot),
    .ctx_ready(ctx_ready_b), .ctx_done(ctx_done_b),
    .ctx_err(ctx_err_b), .registers(registers_b)
  );

  gb_cpu_regfile_mp #(
    .NUM_WR(NW), .NUM_RD(NR), .NUM_CTX(NC), .BYPASS(0)
  ) dut_n (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_pair(wr_pair), .wr_sel(wr_sel),
    .wr_data(wr_data), .wr_ready(wr_ready_n),
    .rd_pair(rd_pair), .rd_sel(rd_sel), .rd_data(rd_data_n),
    .ctx_valid(ctx_valid), .ctx_op(ctx_op), .ctx_slot(ctx_slot),
    .ctx_ready(ctx_ready_n), .ctx_done(ctx_done_n),
    .ctx_err(ctx_err_n), .registers(registers_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int       n_cmp;
  int       n_bad;
  regfile_t m_cur;
  regfile_t m_sh [NC];
  regfile_t snap;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int pair_low(input int s);
    case (s)
      int'(REG_A):     return int'(REG_F);
      int'(REG_B):     return int'(REG_C);
      int'(REG_D):     return int'(REG_E);
      int'(REG_H):     return int'(REG_L);
      int'(REG_SP_H):  return int'(REG_SP_L);
      int'(REG_PC_H):  return int'(REG_PC_L);
      int'(REG_TMP_H): return int'(REG_TMP_L);
      default:         return -1;
    endcase
  endfunction

  function automatic int ctx_hi(input int i);
    case (i)
      0:       return int'(REG_A);
      1:       return int'(REG_B);
      2:       return int'(REG_D);
      3:       return int'(REG_H);
      4:       return int'(REG_SP_H);
      default: return int'(REG_PC_H);
    endcase
  endfunction

  task automatic m_reset();
    m_cur = '0;
    m_cur[REG_A]    = 8'h01;
    m_cur[REG_F]    = 8'hB0;
    m_cur[REG_C]    = 8'h13;
    m_cur[REG_E]    = 8'hD8;
    m_cur[REG_H]    = 8'h01;
    m_cur[REG_L]    = 8'h4D;
    m_cur[REG_SP_H] = 8'hFF;
    m_cur[REG_SP_L] = 8'hFE;
    m_cur[REG_PC_H] = 8'h01;
    for (int i = 0; i < NC; i++) m_sh[i] = '0;
  endtask

  // First enabled port (lowest index) to claim a byte owns it
  function automatic regfile_t apply_writes(input regfile_t cur);
    regfile_t    n = cur;
    bit [15:0]   got = '0;
    int          s;
    int          lo;
    logic [15:0] d;
    for (int p = 0; p < NW; p++) begin
      if (wr_en[p]) begin
        s = int'(wr_sel[p*4 +: 4]);
        d = wr_data[p*16 +: 16];
        if (wr_pair[p]) begin
          lo = pair_low(s);
          if (lo >= 0) begin
            if (!got[s]) begin n[s] = d[15:8]; got[s] = 1'b1; end
            if (!got[lo]) begin n[lo] = d[7:0]; got[lo] = 1'b1; end
          end
        end else if (s < 15 && !got[s]) begin
          n[s] = d[7:0];
          got[s] = 1'b1;
        end
      end
    end
    n[REG_F] = n[REG_F] & 8'hF0;
    return n;
  endfunction

  function automatic logic [15:0] rd_model(input regfile_t b,
                                            input bit pr, input int s);
    int lo;
    if (pr) begin
      lo = pair_low(s);
      if (lo < 0) return 16'h0000;
      return {b[s], b[lo]};
    end
    if (s >= 15) return 16'h0000;
    return {8'h00, b[s]};
  endfunction

  task automatic clr_in();
    wr_en = '0; wr_pair = '0; wr_sel = '0; wr_data = '0;
    ctx_valid = 1'b0; ctx_op = 2'b00; ctx_slot = 2'b00;
  endtask

  task automatic rnd_in();
    wr_en   = NW'($urandom);
    wr_pair = NW'($urandom);
    wr_sel  = (NW*4)'($urandom);
    wr_data = (NW*16)'({$urandom(), $urandom()});
    rd_pair = NR'($urandom);
    rd_sel  = (NR*4)'($urandom);
  endtask

  task automatic set_wr(input int p, input bit pr, input int s,
                        input logic [15:0] d);
    wr_en[p] = 1'b1;
    wr_pair[p] = pr;
    wr_sel[p*4 +: 4] = 4'(s);
    wr_data[p*16 +: 16] = d;
  endtask

  // One idle cycle: read checks before the edge, state checks after
  task automatic tick();
    regfile_t nxt;
    @(negedge clk);
    nxt = apply_writes(m_cur);
    chk("wr_ready", {wr_ready_b, wr_ready_n}, 2'b11);
    for (int r = 0; r < NR; r++) begin
      chk("rd_bypass", rd_data_b[r*16 +: 16],
          rd_model(nxt, rd_pair[r], int'(rd_sel[r*4 +: 4])));
      chk("rd_registered", rd_data_n[r*16 +: 16],
          rd_model(m_cur, rd_pair[r], int'(rd_sel[r*4 +: 4])));
    end
    @(posedge clk);
    m_cur = nxt;
    #1;
    chk("regs_b", registers_b, m_cur);
    chk("regs_n", registers_n, m_cur);
  endtask

  // Issue a context op (writes already on the ports commit at accept)
  task automatic do_ctx(input int op, input int slot);
    regfile_t nxt;
    bit       bad;
    int       dc;
    int       lo;
    int       hi;
    logic [7:0] t;
    ctx_valid = 1'b1;
    ctx_op = 2'(op);
    ctx_slot = 2'(slot);
    @(negedge clk);
    chk("ctx_ready_idle", {ctx_ready_b, ctx_ready_n}, 2'b11);
    nxt = apply_writes(m_cur);
    @(posedge clk);
    m_cur = nxt;
    #1;
    clr_in();
    bad = (op == 3) || (slot >= NC);
    dc = bad ? 1 : 7;
    if (!bad) begin
      for (int i = 0; i < 6; i++) begin
        hi = ctx_hi(i);
        lo = pair_low(hi);
        for (int k = 0; k < 2; k++) begin
          int b = (k == 0) ? hi : lo;
          case (op)
            0: m_sh[slot][b] = m_cur[b];
            1: m_cur[b] = m_sh[slot][b];
            default: begin
              t = m_cur[b];
              m_cur[b] = m_sh[slot][b];
              m_sh[slot][b] = t;
            end
          endcase
        end
      end
    end
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      chk($sformatf("done_c%0d", k), {ctx_done_b, ctx_done_n},
          (k == dc) ? 2'b11 : 2'b00);
      chk($sformatf("wr_ready_c%0d", k), wr_ready_b, 1'(k > dc));
      if (k == dc) chk("ctx_err", {ctx_err_b, ctx_err_n},
                       bad ? 2'b11 : 2'b00);
    end
    chk("ctx_regs_b", registers_b, m_cur);
    chk("ctx_regs_n", registers_n, m_cur);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    clr_in();
    rd_pair = '0;
    rd_sel = '0;
    m_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_regs", registers_b, m_cur);
    chk("reset_af", {registers_b[REG_A], registers_b[REG_F]}, 16'h01B0);
    chk("reset_pc", {registers_b[REG_PC_H], registers_b[REG_PC_L]}, 16'h0100);
    chk("reset_ready", {ctx_ready_b, wr_ready_b, ctx_done_b, ctx_err_b},
        4'b1100);

    set_wr(0, 1'b0, int'(REG_C), 16'h0055);
    set_wr(1, 1'b1, int'(REG_B), 16'h1234);
    tick();
    chk("prio_b", registers_b[REG_B], 8'h12);
    chk("prio_c", registers_b[REG_C], 8'h55);
    clr_in();
    set_wr(2, 1'b0, int'(REG_F), 16'h00FF);
    tick();
    chk("f_mask8", registers_b[REG_F], 8'hF0);
    clr_in();
    set_wr(0, 1'b1, int'(REG_A), 16'h12FF);
    tick();
    chk("f_mask16", {registers_b[REG_A], registers_b[REG_F]}, 16'h12F0);

    clr_in();
    set_wr(1, 1'b1, int'(REG_H), 16'hBEEF);
    rd_pair = 2'b01;
    rd_sel = {4'(REG_NONE), 4'(REG_H)};
    @(negedge clk);
    chk("bypass_hl", rd_data_b[15:0], 16'hBEEF);
    chk("nobypass_hl", rd_data_n[15:0], {m_cur[REG_H], m_cur[REG_L]});
    @(posedge clk);
    m_cur = apply_writes(m_cur);
    #1;
    chk("nobypass_hl_next", rd_data_n[15:0], 16'hBEEF);
    chk("bad_pair_rd", rd_data_b[31:16], 16'h0000);
    clr_in();

    do_ctx(0, 1);
    snap = m_cur;
    set_wr(0, 1'b1, int'(REG_A), 16'hA5A5);
    set_wr(1, 1'b1, int'(REG_B), 16'h1111);
    set_wr(2, 1'b1, int'(REG_D), 16'h2222);
    tick();
    clr_in();
    set_wr(0, 1'b1, int'(REG_H), 16'h3333);
    set_wr(1, 1'b1, int'(REG_SP_H), 16'h4444);
    set_wr(2, 1'b1, int'(REG_PC_H), 16'h5555);
    tick();
    clr_in();
    do_ctx(1, 1);
    for (int i = 0; i < 6; i++) begin
      chk("restore_pair",
          {registers_b[ctx_hi(i)], registers_b[pair_low(ctx_hi(i))]},
          {snap[ctx_hi(i)], snap[pair_low(ctx_hi(i))]});
    end

    set_wr(0, 1'b1, int'(REG_A), 16'h1100);
    tick();
    clr_in();
    do_ctx(0, 0);
    set_wr(0, 1'b1, int'(REG_A), 16'h2200);
    tick();
    clr_in();
    do_ctx(2, 0);
    chk("swap1_af", {registers_b[REG_A], registers_b[REG_F]}, 16'h1100);
    do_ctx(2, 0);
    chk("swap2_af", {registers_b[REG_A], registers_b[REG_F]}, 16'h2200);

    snap = m_cur;
    do_ctx(0, 3);
    do_ctx(3, 1);
    chk("err_nochange", registers_b, snap);

    for (int blk = 0; blk < 10; blk++) begin
      for (int c = 0; c < 15; c++) begin
        rnd_in();
        tick();
      end
      rnd_in();
      do_ctx(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    set_wr(0, 1'b1, int'(REG_D), 16'hCAFE);
    do_ctx(0, 2);
    do_ctx(1, 2);
    chk("accept_write", {registers_b[REG_D], registers_b[REG_E]}, 16'hCAFE);

    ctx_valid = 1'b1;
    ctx_op = 2'b00;
    ctx_slot = 2'd0;
    @(posedge clk);
    #1;
    clr_in();
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    m_reset();
    chk("midcopy_reset_regs", registers_b, m_cur);
    chk("midcopy_reset_ready", {ctx_ready_b, ctx_done_b}, 2'b10);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("no_done_after_reset", {ctx_done_b, ctx_done_n}, 2'b00);
    end
    @(posedge clk);
    #1;
    do_ctx(1, 0);
    chk("shadow_cleared_af", {registers_b[REG_A], registers_b[REG_F]},
        16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
